// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between instruction fetch (IF) and load/store (LS).
// One outstanding transaction; LS has priority, bounded by a streak limit so IF is never starved.
module mem_bus_arbiter #(
   parameter int ADDR_W        = 64,
   parameter int DATA_W        = 64,
   parameter int MAX_LS_STREAK = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  if_req_valid,
   input  logic [ADDR_W-1:0]     if_addr,
   output logic                  if_req_ready,
   output logic                  if_rsp_valid,
   output logic [DATA_W-1:0]     if_rdata,

   input  logic                  ls_req_valid,
   input  logic [ADDR_W-1:0]     ls_addr,
   input  logic                  ls_wen,
   input  logic [DATA_W-1:0]     ls_wdata,
   input  logic [DATA_W/8-1:0]   ls_wmask,
   output logic                  ls_req_ready,
   output logic                  ls_rsp_valid,
   output logic [DATA_W-1:0]     ls_rdata,

   output logic                  bus_req_valid,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic                  bus_wen,
   output logic [DATA_W-1:0]     bus_wdata,
   output logic [DATA_W/8-1:0]   bus_wmask,
   input  logic                  bus_req_ready,
   input  logic                  bus_rsp_valid,
   input  logic [DATA_W-1:0]     bus_rdata,

   output logic                  busy
);

   // state   | meaning
   // IDLE    | arbitrate; latch winner's request on grant
   // REQ     | request presented on the bus, waiting for bus_req_ready
   // WAIT    | request accepted, waiting for bus_rsp_valid
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] LS_LIMIT = 2'(MAX_LS_STREAK);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_owner;        // 1 = LS owns the outstanding transaction
   logic [1:0]             r_ls_streak;
   logic [ADDR_W-1:0]      r_bus_addr;
   logic                   r_bus_wen;
   logic [DATA_W-1:0]      r_bus_wdata;
   logic [DATA_W/8-1:0]    r_bus_wmask;

   logic                   w_grant_ls;
   logic                   w_grant_if;
   logic                   w_rsp_fire;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_ls  = 1'b0;
      w_grant_if  = 1'b0;
      w_rsp_fire  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ls_req_valid && !(if_req_valid && (r_ls_streak == LS_LIMIT))) begin
               w_grant_ls = 1'b1;
            end else if (if_req_valid) begin
               w_grant_if = 1'b1;
            end
            if (w_grant_ls || w_grant_if) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_req_ready) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus_rsp_valid) begin
               w_rsp_fire  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner     <= 1'b0;
         r_ls_streak <= 2'd0;
         r_bus_addr  <= '0;
         r_bus_wen   <= 1'b0;
         r_bus_wdata <= '0;
         r_bus_wmask <= '0;
      end else if (w_grant_ls) begin
         r_owner     <= 1'b1;
         r_bus_addr  <= ls_addr;
         r_bus_wen   <= ls_wen;
         r_bus_wdata <= ls_wdata;
         r_bus_wmask <= ls_wmask;
         // streak only counts LS wins that actually held IF off
         if (if_req_valid && (r_ls_streak != 2'd3)) begin
            r_ls_streak <= r_ls_streak + 2'd1;
         end
      end else if (w_grant_if) begin
         r_owner     <= 1'b0;
         r_ls_streak <= 2'd0;
         r_bus_addr  <= if_addr;
         r_bus_wen   <= 1'b0;
         r_bus_wdata <= '0;
         r_bus_wmask <= '0;
      end
   end

   assign if_req_ready  = rst_n & w_grant_if;
   assign ls_req_ready  = rst_n & w_grant_ls;
   assign if_rsp_valid  = rst_n & w_rsp_fire & ~r_owner;
   assign ls_rsp_valid  = rst_n & w_rsp_fire &  r_owner;
   assign if_rdata      = if_rsp_valid ? bus_rdata : '0;
   assign ls_rdata      = ls_rsp_valid ? bus_rdata : '0;

   assign bus_req_valid = (r_state == ST_REQ);
   assign bus_addr      = r_bus_addr;
   assign bus_wen       = r_bus_wen;
   assign bus_wdata     = r_bus_wdata;
   assign bus_wmask     = r_bus_wmask;
   assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents a grant or response.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_valid;
   logic [63:0] if_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [63:0] if_rdata;
   logic        ls_req_valid;
   logic [63:0] ls_addr;
   logic        ls_wen;
   logic [63:0] ls_wdata;
   logic [7:0]  ls_wmask;
   logic        ls_req_ready;
   logic        ls_rsp_valid;
   logic [63:0] ls_rdata;
   logic        bus_req_valid;
   logic [63:0] bus_addr;
   logic        bus_wen;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_req_ready;
   logic        bus_rsp_valid;
   logic [63:0] bus_rdata;
   logic        busy;

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LS_STREAK(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_addr(ls_addr), .ls_wen(ls_wen),
      .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
      .bus_req_valid(bus_req_valid), .bus_addr(bus_addr), .bus_wen(bus_wen),
      .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_req_ready(bus_req_ready),
      .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        owner;   // 1 = LS
      logic [63:0] data;
   } rsp_t;

   rsp_t exp_rsp_q[$];
   logic exp_gnt_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // monitor: grants and responses are checked against the expectation queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (if_req_ready || ls_req_ready) begin
            if (exp_gnt_q.size() == 0) begin
               chk("grant_unexpected", 64'(ls_req_ready), 64'(!ls_req_ready));
            end else begin
               logic g;
               g = exp_gnt_q.pop_front();
               chk("grant_owner", 64'(ls_req_ready), 64'(g));
               chk("grant_onehot", 64'(if_req_ready & ls_req_ready), 64'd0);
            end
         end
         if (if_rsp_valid || ls_rsp_valid) begin
            if (exp_rsp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(ls_rsp_valid), 64'(!ls_rsp_valid));
            end else begin
               rsp_t r;
               r = exp_rsp_q.pop_front();
               chk("rsp_owner", 64'(ls_rsp_valid), 64'(r.owner));
               chk("rsp_onehot", 64'(if_rsp_valid & ls_rsp_valid), 64'd0);
               chk("rsp_data", ls_rsp_valid ? ls_rdata : if_rdata, r.data);
            end
         end
         if (!if_rsp_valid) chk("if_rdata_zero", if_rdata, 64'd0);
         if (!ls_rsp_valid) chk("ls_rdata_zero", ls_rdata, 64'd0);
      end
   end

   // Called at posedge+1 of the REQ cycle; returns at posedge+1 of the cycle after the response.
   task automatic serve(input int stall, input logic [63:0] rdata, input logic [63:0] ea,
                        input logic ew, input logic [63:0] ewd, input logic [7:0] em);
      for (int k = 0; k <= stall; k++) begin
         bus_req_ready = (k == stall);
         @(negedge clk);
         chk("req_bus_valid", 64'(bus_req_valid), 64'd1);
         chk("req_bus_addr", bus_addr, ea);
         chk("req_bus_wen", 64'(bus_wen), 64'(ew));
         chk("req_bus_wdata", bus_wdata, ewd);
         chk("req_bus_wmask", 64'(bus_wmask), 64'(em));
         chk("req_no_ready", 64'(if_req_ready | ls_req_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b1;
      bus_rdata     = rdata;
      @(negedge clk);
      chk("wait_bus_valid", 64'(bus_req_valid), 64'd0);
      chk("wait_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      bus_rdata     = '0;
   endtask

   localparam logic [63:0] IF_A = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LS_A = 64'h0000_0000_8000_1000;

   initial begin
      logic [1:0] exp_streak [6];
      exp_streak = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

      rst_n = 1'b0;
      if_req_valid = 1'b1; if_addr = IF_A;
      ls_req_valid = 1'b1; ls_addr = LS_A; ls_wen = 1'b1;
      ls_wdata = 64'hFFFF; ls_wmask = 8'hFF;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 64'hAAAA;

      // reset: registered outputs cleared, combinational outputs forced low
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_if_req_ready", 64'(if_req_ready), 64'd0);
      chk("rst_ls_req_ready", 64'(ls_req_ready), 64'd0);
      chk("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
      chk("rst_ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
      chk("rst_if_rdata", if_rdata, 64'd0);
      chk("rst_ls_rdata", ls_rdata, 64'd0);
      chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
      chk("rst_bus_addr", bus_addr, 64'd0);
      chk("rst_bus_wen", 64'(bus_wen), 64'd0);
      chk("rst_bus_wdata", bus_wdata, 64'd0);
      chk("rst_bus_wmask", 64'(bus_wmask), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      bus_rsp_valid = 1'b0; bus_rdata = '0;
      ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
      @(posedge clk); #1;

      // single IF read, minimum latency
      if_req_valid = 1'b1; if_addr = IF_A;
      exp_gnt_q.push_back(1'b0);
      exp_rsp_q.push_back('{owner: 1'b0, data: 64'h0000_0013_0000_0093});
      @(negedge clk);
      chk("if_grant_c0", 64'(if_req_ready), 64'd1);
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      serve(0, 64'h0000_0013_0000_0093, IF_A, 1'b0, 64'd0, 8'h00);

      // LS store with a 3-cycle bus stall
      ls_req_valid = 1'b1; ls_addr = LS_A; ls_wen = 1'b1;
      ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F;
      exp_gnt_q.push_back(1'b1);
      exp_rsp_q.push_back('{owner: 1'b1, data: 64'd0});
      @(negedge clk);
      chk("ls_grant_c0", 64'(ls_req_ready), 64'd1);
      @(posedge clk); #1;
      ls_req_valid = 1'b0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
      serve(3, 64'd0, LS_A, 1'b1, 64'hDEAD_BEEF, 8'h0F);
      @(negedge clk);
      chk("store_idle_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // spurious response in IDLE
      bus_rsp_valid = 1'b1; bus_rdata = 64'h5555;
      @(negedge clk);
      chk("spur_idle_busy", 64'(busy), 64'd0);
      chk("spur_idle_rsp", 64'(if_rsp_valid | ls_rsp_valid), 64'd0);
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0; bus_rdata = '0;

      // spurious response during a stalled REQ
      if_req_valid = 1'b1; if_addr = IF_A + 64'h40;
      exp_gnt_q.push_back(1'b0);
      exp_rsp_q.push_back('{owner: 1'b0, data: 64'h0BAD_F00D});
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 64'h6666;
      @(negedge clk);
      chk("spur_req_rsp", 64'(if_rsp_valid | ls_rsp_valid), 64'd0);
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("spur_req_held", 64'(bus_req_valid), 64'd1);
      @(posedge clk); #1;
      serve(0, 64'h0BAD_F00D, IF_A + 64'h40, 1'b0, 64'd0, 8'h00);

      // contention, both held valid: LS, LS, IF, LS, LS, IF
      if_req_valid = 1'b1; if_addr = IF_A + 64'h80;
      ls_req_valid = 1'b1; ls_addr = LS_A + 64'h8; ls_wen = 1'b0;
      ls_wdata = 64'h1234; ls_wmask = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         logic g;
         g = (i % 3) != 2;
         exp_gnt_q.push_back(g);
         exp_rsp_q.push_back('{owner: g, data: 64'hC0DE_0000 + 64'(i)});
         @(negedge clk);
         chk("cont_streak", 64'(dut.r_ls_streak), 64'(exp_streak[i]));
         @(posedge clk); #1;
         if (g) serve(0, 64'hC0DE_0000 + 64'(i), LS_A + 64'h8, 1'b0, 64'h1234, 8'hFF);
         else   serve(0, 64'hC0DE_0000 + 64'(i), IF_A + 64'h80, 1'b0, 64'd0, 8'h00);
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      ls_wdata = '0; ls_wmask = '0;
      @(posedge clk); #1;

      // reset while in WAIT drops the transaction
      if_req_valid = 1'b1; if_addr = IF_A + 64'hC0;
      exp_gnt_q.push_back(1'b0);
      @(posedge clk); #1;
      if_req_valid = 1'b0; bus_req_ready = 1'b1;
      @(posedge clk); #1;
      bus_req_ready = 1'b0;
      @(negedge clk);
      chk("rw_busy_wait", 64'(busy), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 64'h7777;
      @(negedge clk);
      chk("rw_busy_after", 64'(busy), 64'd0);
      chk("rw_late_rsp", 64'(if_rsp_valid | ls_rsp_valid), 64'd0);
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0; bus_rdata = '0;
      if_req_valid = 1'b1; if_addr = IF_A + 64'h100;
      exp_gnt_q.push_back(1'b0);
      exp_rsp_q.push_back('{owner: 1'b0, data: 64'hFEED_0001});
      @(negedge clk);
      chk("rw_regrant", 64'(if_req_ready), 64'd1);
      @(posedge clk); #1;
      if_req_valid = 1'b0;
      serve(1, 64'hFEED_0001, IF_A + 64'h100, 1'b0, 64'd0, 8'h00);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("gnt_q_left", 64'(exp_gnt_q.size()), 64'd0);
      chk("rsp_q_left", 64'(exp_rsp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
